// File: rtl/alu_issue_stage.sv
// Issue/writeback stage around an external combinational Alu: decodes instruction
// words, reads an 8-entry register file, drives registered Alu inputs and retires results.
module alu_issue_stage #(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned REG_N  = 8,
   parameter int unsigned CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              instr_valid,
   output logic              instr_ready,
   input  logic [15:0]       instr,
   input  logic [DATA_W-1:0] instr_imm,
   output logic [DATA_W-1:0] alu_a,
   output logic [DATA_W-1:0] alu_b,
   output logic [4:0]        alu_opcode,
   input  logic [DATA_W-1:0] alu_result,
   input  logic [4:0]        alu_flags,
   output logic [4:0]        flags,
   output logic              wb_valid,
   output logic [2:0]        wb_addr,
   output logic [DATA_W-1:0] wb_data,
   output logic              illegal_op,
   input  logic [2:0]        dbg_addr,
   output logic [DATA_W-1:0] dbg_data,
   output logic [CNT_W-1:0]  retired_cnt
);

   localparam logic [4:0] OP_CMP  = 5'b01111;
   localparam logic [4:0] OP_HOLE = 5'b01011;

   typedef enum logic {
      S_IDLE,
      S_EXEC
   } state_t;

   state_t            r_state;
   logic [DATA_W-1:0] r_rf [REG_N];
   logic [2:0]        r_rd;
   logic              r_wb_en;

   logic [4:0]        w_op;
   logic [2:0]        w_rd;
   logic [2:0]        w_ra;
   logic [2:0]        w_rb;
   logic              w_imm_sel;
   logic              w_wb_en;
   logic              w_legal;
   logic              w_accept;
   logic              w_commit;

   // Instruction word: {opcode, rd, ra, rb, imm_sel, wb_en}
   assign w_op      = instr[15:11];
   assign w_rd      = instr[10:8];
   assign w_ra      = instr[7:5];
   assign w_rb      = instr[4:2];
   assign w_imm_sel = instr[1];
   assign w_wb_en   = instr[0];

   // Legal encodings are 00000-01111 except the 01011 hole.
   assign w_legal  = (w_op[4] == 1'b0) && (w_op != OP_HOLE);
   assign w_accept = instr_valid && instr_ready;
   assign w_commit = r_wb_en && (alu_opcode != OP_CMP);

   assign instr_ready = (r_state == S_IDLE) && !rst;
   assign dbg_data    = r_rf[dbg_addr];

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_rd        <= '0;
         r_wb_en     <= 1'b0;
         alu_a       <= '0;
         alu_b       <= '0;
         alu_opcode  <= '0;
         flags       <= '0;
         wb_valid    <= 1'b0;
         wb_addr     <= '0;
         wb_data     <= '0;
         illegal_op  <= 1'b0;
         retired_cnt <= '0;
         for (int unsigned i = 0; i < REG_N; i++) begin
            r_rf[i] <= '0;
         end
      end else begin
         wb_valid   <= 1'b0;
         illegal_op <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  if (w_legal) begin
                     alu_a      <= r_rf[w_ra];
                     alu_b      <= w_imm_sel ? instr_imm : r_rf[w_rb];
                     alu_opcode <= w_op;
                     r_rd       <= w_rd;
                     r_wb_en    <= w_wb_en;
                     r_state    <= S_EXEC;
                  end else begin
                     illegal_op <= 1'b1;
                  end
               end
            end
            S_EXEC: begin
               // Write lands here, one edge before the earliest next accept, so no bypass.
               flags <= alu_flags;
               if (w_commit) begin
                  r_rf[r_rd] <= alu_result;
                  wb_valid   <= 1'b1;
                  wb_addr    <= r_rd;
                  wb_data    <= alu_result;
               end
               retired_cnt <= retired_cnt + CNT_W'(1);
               r_state     <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_issue_stage.sv
// Randomized self-checking bench for alu_issue_stage with a behavioural Alu and
// an instruction-level reference model of the register file, flags and counter.
module tb_alu_issue_stage;

   logic        clk;
   logic        rst;
   logic        instr_valid;
   logic        instr_ready;
   logic [15:0] instr;
   logic [7:0]  instr_imm;
   logic [7:0]  alu_a;
   logic [7:0]  alu_b;
   logic [4:0]  alu_opcode;
   logic [7:0]  alu_result;
   logic [4:0]  alu_flags;
   logic [4:0]  flags;
   logic        wb_valid;
   logic [2:0]  wb_addr;
   logic [7:0]  wb_data;
   logic        illegal_op;
   logic [2:0]  dbg_addr;
   logic [7:0]  dbg_data;
   logic [15:0] retired_cnt;

   int unsigned n_checks;
   int unsigned n_errors;

   logic [7:0]  m_rf [8];
   logic [4:0]  m_flags;
   logic [15:0] m_cnt;
   logic [4:0]  m_opc;

   alu_issue_stage #(.DATA_W(8), .REG_N(8), .CNT_W(16)) dut (
      .clk         (clk),
      .rst         (rst),
      .instr_valid (instr_valid),
      .instr_ready (instr_ready),
      .instr       (instr),
      .instr_imm   (instr_imm),
      .alu_a       (alu_a),
      .alu_b       (alu_b),
      .alu_opcode  (alu_opcode),
      .alu_result  (alu_result),
      .alu_flags   (alu_flags),
      .flags       (flags),
      .wb_valid    (wb_valid),
      .wb_addr     (wb_addr),
      .wb_data     (wb_data),
      .illegal_op  (illegal_op),
      .dbg_addr    (dbg_addr),
      .dbg_data    (dbg_data),
      .retired_cnt (retired_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural Alu: returns {carry, zero, parity, overflow, borrow, result}.
   function automatic logic [12:0] alu_fn(input logic [7:0] a, input logic [7:0] b,
                                          input logic [4:0] op);
      logic [8:0] s;
      logic [7:0] r;
      logic       c;
      logic       v;
      logic       bw;
      c = 1'b0; v = 1'b0; bw = 1'b0; r = 8'h00;
      case (op)
         5'd0: begin
            s = {1'b0, a} + {1'b0, b};
            r = s[7:0];
            c = s[8];
            v = (a[7] == b[7]) && (r[7] != a[7]);
         end
         5'd1, 5'd15: begin
            r  = a - b;
            bw = (a < b);
            v  = (a[7] != b[7]) && (r[7] != a[7]);
         end
         5'd2:  r = a & b;
         5'd3:  r = a | b;
         5'd4:  r = a ^ b;
         5'd5:  r = ~a;
         5'd6:  begin r = a << 1; c = a[7]; end
         5'd7:  begin r = a >> 1; c = a[0]; end
         5'd8:  begin r = a + 8'd1; c = (a == 8'hFF); end
         5'd9:  begin r = a - 8'd1; bw = (a == 8'h00); end
         5'd10: r = b;
         5'd12: r = ~(a & b);
         5'd13: r = ~(a | b);
         5'd14: r = ~(a ^ b);
         default: r = 8'h00;
      endcase
      return {c, (r == 8'h00), ^r, v, bw, r};
   endfunction

   always_comb {alu_flags, alu_result} = alu_fn(alu_a, alu_b, alu_opcode);

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 8; i++) m_rf[i] = 8'h00;
      m_flags = 5'h00;
      m_cnt   = 16'h0000;
      m_opc   = 5'h00;
   endtask

   // Presents one instruction at a falling edge and checks its whole life.
   // keep=1 leaves instr_valid high so the next call streams back-to-back.
   task automatic issue(input logic [4:0] op, input logic [2:0] rd, input logic [2:0] ra,
                        input logic [2:0] rb, input logic imm_sel, input logic wb_en,
                        input logic [7:0] imm, input logic keep);
      logic [12:0] fr;
      logic [7:0]  exp_a;
      logic [7:0]  exp_b;
      logic        legal;
      logic        wr;
      int unsigned n;
      instr       = {op, rd, ra, rb, imm_sel, wb_en};
      instr_imm   = imm;
      instr_valid = 1'b1;
      n = 0;
      while (!instr_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("ready_at_issue", {31'd0, instr_ready}, 32'd1);
      if (!instr_ready) begin
         instr_valid = 1'b0;
         return;
      end
      legal = (op < 5'd16) && (op != 5'd11);
      exp_a = m_rf[ra];
      exp_b = imm_sel ? imm : m_rf[rb];
      @(posedge clk);
      @(negedge clk);
      if (!keep) instr_valid = 1'b0;
      if (!legal) begin
         check("illegal_pulse", {31'd0, illegal_op}, 32'd1);
         check("illegal_opc_hold", {27'd0, alu_opcode}, {27'd0, m_opc});
         check("illegal_ready", {31'd0, instr_ready}, 32'd1);
         check("illegal_cnt", {16'd0, retired_cnt}, {16'd0, m_cnt});
         check("illegal_flags", {27'd0, flags}, {27'd0, m_flags});
         check("illegal_no_wb", {31'd0, wb_valid}, 32'd0);
      end else begin
         check("exec_ready", {31'd0, instr_ready}, 32'd0);
         check("alu_a", {24'd0, alu_a}, {24'd0, exp_a});
         check("alu_b", {24'd0, alu_b}, {24'd0, exp_b});
         check("alu_opcode", {27'd0, alu_opcode}, {27'd0, op});
         check("exec_no_illegal", {31'd0, illegal_op}, 32'd0);
         fr      = alu_fn(exp_a, exp_b, op);
         m_flags = fr[12:8];
         wr      = wb_en && (op != 5'd15);
         if (wr) m_rf[rd] = fr[7:0];
         m_cnt   = m_cnt + 16'd1;
         m_opc   = op;
         @(negedge clk);
         check("wb_valid", {31'd0, wb_valid}, {31'd0, wr});
         if (wr) begin
            check("wb_addr", {29'd0, wb_addr}, {29'd0, rd});
            check("wb_data", {24'd0, wb_data}, {24'd0, m_rf[rd]});
         end
         check("flags", {27'd0, flags}, {27'd0, m_flags});
         check("retired_cnt", {16'd0, retired_cnt}, {16'd0, m_cnt});
         check("ready_after", {31'd0, instr_ready}, 32'd1);
         dbg_addr = rd;
         #1;
         check("dbg_rd", {24'd0, dbg_data}, {24'd0, m_rf[rd]});
      end
   endtask

   task automatic check_all_regs(input string tag);
      for (int i = 0; i < 8; i++) begin
         dbg_addr = 3'(i);
         #1;
         check(tag, {24'd0, dbg_data}, {24'd0, m_rf[i]});
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [4:0]  rop;
      logic        rkeep;
      n_checks    = 0;
      n_errors    = 0;
      rst         = 1'b1;
      instr_valid = 1'b0;
      instr       = 16'h0000;
      instr_imm   = 8'h00;
      dbg_addr    = 3'd0;
      model_reset();

      repeat (3) @(negedge clk);
      check("rst_ready", {31'd0, instr_ready}, 32'd0);
      check("rst_alu_a", {24'd0, alu_a}, 32'd0);
      check("rst_alu_b", {24'd0, alu_b}, 32'd0);
      check("rst_alu_opcode", {27'd0, alu_opcode}, 32'd0);
      check("rst_flags", {27'd0, flags}, 32'd0);
      check("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
      check("rst_wb_addr", {29'd0, wb_addr}, 32'd0);
      check("rst_wb_data", {24'd0, wb_data}, 32'd0);
      check("rst_illegal", {31'd0, illegal_op}, 32'd0);
      check("rst_cnt", {16'd0, retired_cnt}, 32'd0);
      rst = 1'b0;
      @(negedge clk);
      check("release_ready", {31'd0, instr_ready}, 32'd1);
      check_all_regs("rst_dbg");

      // ADD r1=r0+#5A, ADD r2=r1+#CD -> 0x27 with carry
      issue(5'd0, 3'd1, 3'd0, 3'd0, 1'b1, 1'b1, 8'h5A, 1'b0);
      check("add1_data", {24'd0, wb_data}, 32'h5A);
      issue(5'd0, 3'd2, 3'd1, 3'd0, 1'b1, 1'b1, 8'hCD, 1'b0);
      check("add2_data", {24'd0, wb_data}, 32'h27);
      check("add2_carry", {31'd0, flags[4]}, 32'd1);
      check("add2_cnt", {16'd0, retired_cnt}, 32'd2);

      // Back-to-back stream with a dependent SUB reading the fresh r4
      issue(5'd0, 3'd4, 3'd1, 3'd0, 1'b1, 1'b1, 8'h03, 1'b1);
      issue(5'd1, 3'd5, 3'd4, 3'd1, 1'b0, 1'b1, 8'h00, 1'b1);
      check("dep_sub", {24'd0, wb_data}, 32'h03);
      issue(5'd4, 3'd6, 3'd4, 3'd2, 1'b0, 1'b1, 8'h00, 1'b1);
      issue(5'd3, 3'd7, 3'd6, 3'd6, 1'b1, 1'b0, 8'hF0, 1'b0);

      // CMP r1,#5A: flags only, r1 unchanged
      issue(5'd15, 3'd1, 3'd1, 3'd0, 1'b1, 1'b1, 8'h5A, 1'b0);
      check("cmp_zero", {31'd0, flags[3]}, 32'd1);
      dbg_addr = 3'd1;
      #1;
      check("cmp_r1", {24'd0, dbg_data}, 32'h5A);

      issue(5'b10000, 3'd3, 3'd1, 3'd1, 1'b0, 1'b1, 8'h00, 1'b0);
      issue(5'b01011, 3'd3, 3'd1, 3'd1, 1'b0, 1'b1, 8'h00, 1'b0);

      for (int i = 0; i < 200; i++) begin
         rop   = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(0, 31))
                                             : 5'($urandom_range(0, 15));
         rkeep = 1'($urandom_range(0, 1));
         issue(rop, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
               3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 3) != 0), 8'($urandom_range(0, 255)), rkeep);
      end
      instr_valid = 1'b0;
      check_all_regs("rand_dbg");

      // Reset during EXEC of ADD r3=r0+#11 aborts the instruction
      instr       = {5'd0, 3'd3, 3'd0, 3'd0, 1'b1, 1'b1};
      instr_imm   = 8'h11;
      instr_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      instr_valid = 1'b0;
      rst         = 1'b1;
      @(negedge clk);
      check("abort_no_wb", {31'd0, wb_valid}, 32'd0);
      check("abort_flags", {27'd0, flags}, 32'd0);
      check("abort_cnt", {16'd0, retired_cnt}, 32'd0);
      check("abort_ready", {31'd0, instr_ready}, 32'd0);
      model_reset();
      check_all_regs("abort_dbg");
      rst = 1'b0;
      @(negedge clk);
      issue(5'd0, 3'd3, 3'd0, 3'd0, 1'b1, 1'b1, 8'h11, 1'b0);
      check("post_abort_data", {24'd0, wb_data}, 32'h11);
      check("post_abort_cnt", {16'd0, retired_cnt}, 32'd1);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
